iic_slave_responder: RTL and testbench
======================================

# iic_slave_responder

I2C slave (responder) for the SHT21 bus, the other end of the 8-bit IIC read/write master controller. It decodes START, slave-address+W, a one-byte command, repeated START, slave-address+R, and then returns two data bytes (MSB, then LSB) from host-supplied registers. It serves two purposes: it is the bus-functional sensor model in the controller testbench, and it is a synthesizable target for FPGA-to-FPGA links. It never stretches SCL.

## Interface
Parameters:
- SLAVE_ADDR, 7'h40, 7-bit device address; write byte = {SLAVE_ADDR,0}, read byte = {SLAVE_ADDR,1}.

Ports:
- clk  input  1  system clock, the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock, sampled only.
- sda  inout  1  I2C data, open-drain: driven 1'b0 or released to 1'bz, never driven 1.
- rd_ms  input  8  MSB to return on read.
- rd_ls  input  8  LSB to return on read.
- cmd_byte  output  8  last command byte acknowledged.
- cmd_valid  output  1  one-cycle pulse when cmd_byte updates.
- rd_done  output  1  one-cycle pulse after the master's ACK/NACK bit for the LSB has been sampled.
- busy  output  1  high while the FSM is not in IDLE.

## Operation
- scl and sda each pass through a 2-FF synchronizer. A third register provides edge detection.
- START: synchronized sda falls while scl is high. STOP: synchronized sda rises while scl is high. START and STOP are recognized in every state.
- A START in any state (including a repeated START) enters ADDR with bit count 0 and releases sda.
- A STOP in any state enters IDLE and releases sda. A partial byte is discarded.
- Data bits are sampled on the scl rising edge, MSB first. The slave changes sda only on an scl falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX, TX_ACK, WAIT.
- ADDR: shift in 8 bits. On the falling edge after bit 8:
  - Address matches and R/W=0: drive sda low, go to ADDR_ACK with a write flag.
  - Address matches and R/W=1: drive sda low, latch {rd_ms, rd_ls} into a 16-bit shadow, clear the byte index, go to ADDR_ACK with a read flag.
  - Address does not match: keep sda released and go to WAIT.
- ADDR_ACK: on the next scl falling edge, release sda.
  - Write flag: go to CMD.
  - Read flag: drive shadow bit 15 and go to TX.
- CMD: shift in 8 bits. On the falling edge after bit 8: drive sda low, load cmd_byte, pulse cmd_valid, go to CMD_ACK.
- CMD_ACK: on the next falling edge, release sda and go to WAIT. Further write bytes are not acknowledged.
- TX: on each scl falling edge, drive the next shadow bit (a 0 bit drives low, a 1 bit releases sda). After the falling edge that ends bit 8, release sda and go to TX_ACK.
- TX_ACK: sample sda on the scl rising edge.
  - Byte index 0 and ACK (sda=0): on the next falling edge, set byte index to 1, drive shadow bit 7, go to TX.
  - Byte index 0 and NACK: go to WAIT. No rd_done pulse.
  - Byte index 1: pulse rd_done, go to WAIT, regardless of ACK or NACK.
- WAIT: sda released. The FSM leaves WAIT only on START or STOP.
- Shadow latching: changes on rd_ms/rd_ls after the address ACK do not affect the current transfer.

## Timing
- Reset values: sda released (z), cmd_byte=8'h00, cmd_valid=0, rd_done=0, busy=0, FSM in IDLE, shadow=0.
- Reset asserted mid-transfer releases sda asynchronously.
- Detection latency: 3 clk cycles from a bus edge to the internal event.
- sda update latency: 1 clk after the detected scl falling edge, i.e. 4 clk after the pin edge.
- Requirements on the bus master:
  - clk frequency ≥ 16× the SCL frequency.
  - Master holds sda for ≥ 4 clk after the scl falling edge.
- Requirements on the block:
  - When the slave drives sda, it holds sda stable from 1 clk after the detected scl falling edge until the next detected falling edge.
  - No sda transition while scl is high, except when releasing sda on reset or on START/STOP recovery.
- cmd_valid and rd_done are exactly 1 clk wide and are never asserted in the same cycle.
- busy rises 1 clk after START is detected and falls 1 clk after STOP is detected.

## Test plan
- Write 0x80 then 0xE3, then STOP → slave drives ACK low on both 9th clocks. cmd_byte=0xE3 with one cmd_valid pulse. busy returns to 0 after STOP.
- Write 0x80, 0xE5, repeated START, 0x81, with rd_ms=0x66 and rd_ls=0x5C; master ACKs the MSB and NACKs the LSB → master reads 0x66 then 0x5C; one rd_done pulse; sda released.
- Write 0x82 (address mismatch) → sda stays high on the 9th clock, no cmd_valid, FSM in WAIT until STOP.
- Read 0x81; master NACKs after the MSB, then issues STOP → only 0x66 is sent, sda is released during the LSB slot, no rd_done.
- rd_ms changed from 0x66 to 0x11 during the MSB transfer → master still reads 0x66.
- Assert rst_n low mid-MSB while the slave is driving sda low → sda goes z immediately and all outputs are at reset values. A following START and 0x80 transfer is acknowledged normally.

Source files
------------

// File: rtl/iic_slave_responder.sv
// ----------------------------------------------------------------------------
// iic_slave_responder
//
// I2C responder for the SHT21 bus. It decodes START, address+W, one command
// byte, repeated START and address+R, then returns two bytes (MSB, then LSB)
// taken from rd_ms/rd_ls. The two bytes are captured when the read address is
// acknowledged. SCL is never stretched.
//
// Ports:
//   clk       system clock (only clock of the block)
//   rst_n     asynchronous active-low reset
//   scl       I2C clock, sampled only
//   sda       I2C data, open-drain (driven 0 or released to z)
//   rd_ms     MSB returned on read
//   rd_ls     LSB returned on read
//   cmd_byte  last acknowledged command byte
//   cmd_valid one-cycle pulse when cmd_byte updates
//   rd_done   one-cycle pulse once the master's bit after the LSB is sampled
//   busy      high while the FSM is not idle
// ----------------------------------------------------------------------------
module iic_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] rd_ms,
  input  logic [7:0] rd_ls,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       rd_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_CMD,
    S_CMD_ACK,
    S_TX,
    S_TX_ACK,
    S_WAIT
  } state_t;

  // Two synchronizer stages plus one history stage per bus line
  logic scl_meta_reg, scl_sync_reg, scl_prev_reg;
  logic sda_meta_reg, sda_sync_reg, sda_prev_reg;

  state_t      state_reg;
  logic [3:0]  bit_cnt_reg;
  logic [7:0]  rx_byte_reg;
  logic        rw_read_reg;
  logic [15:0] shadow_reg;
  logic        byte_idx_reg;
  logic        ack_seen_reg;
  logic        sda_low_reg;
  logic [7:0]  cmd_byte_reg;
  logic        cmd_valid_reg;
  logic        rd_done_reg;
  logic        busy_reg;

  logic       scl_rise;
  logic       scl_fall;
  logic       bus_start;
  logic       bus_stop;
  logic [3:0] tx_bit_idx;

  assign scl_rise  = scl_sync_reg & ~scl_prev_reg;
  assign scl_fall  = ~scl_sync_reg & scl_prev_reg;
  assign bus_start = scl_sync_reg & scl_prev_reg & sda_prev_reg & ~sda_sync_reg;
  assign bus_stop  = scl_sync_reg & scl_prev_reg & ~sda_prev_reg & sda_sync_reg;

  // Next shadow bit to drive: byte 0 walks bits 15..8, byte 1 walks 7..0.
  // bit_cnt_reg holds the number of bits of the current byte already driven.
  assign tx_bit_idx = {~byte_idx_reg, ~bit_cnt_reg[2:0]};

  // Open drain: only ever pull low or let go
  assign sda = sda_low_reg ? 1'b0 : 1'bz;

  assign cmd_byte  = cmd_byte_reg;
  assign cmd_valid = cmd_valid_reg;
  assign rd_done   = rd_done_reg;
  assign busy      = busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_reg  <= 1'b1;
      scl_sync_reg  <= 1'b1;
      scl_prev_reg  <= 1'b1;
      sda_meta_reg  <= 1'b1;
      sda_sync_reg  <= 1'b1;
      sda_prev_reg  <= 1'b1;
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= 4'd0;
      rx_byte_reg   <= 8'h00;
      rw_read_reg   <= 1'b0;
      shadow_reg    <= 16'h0000;
      byte_idx_reg  <= 1'b0;
      ack_seen_reg  <= 1'b0;
      sda_low_reg   <= 1'b0;
      cmd_byte_reg  <= 8'h00;
      cmd_valid_reg <= 1'b0;
      rd_done_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      scl_meta_reg  <= scl;
      scl_sync_reg  <= scl_meta_reg;
      scl_prev_reg  <= scl_sync_reg;
      sda_meta_reg  <= sda;
      sda_sync_reg  <= sda_meta_reg;
      sda_prev_reg  <= sda_sync_reg;
      cmd_valid_reg <= 1'b0;
      rd_done_reg   <= 1'b0;

      if (bus_stop) begin
        state_reg   <= S_IDLE;
        bit_cnt_reg <= 4'd0;
        sda_low_reg <= 1'b0;
        busy_reg    <= 1'b0;
      end else if (bus_start) begin
        state_reg   <= S_ADDR;
        bit_cnt_reg <= 4'd0;
        sda_low_reg <= 1'b0;
        busy_reg    <= 1'b1;
      end else begin
        case (state_reg)
          S_ADDR, S_CMD: begin
            if (scl_rise && bit_cnt_reg != 4'd8) begin
              rx_byte_reg <= {rx_byte_reg[6:0], sda_sync_reg};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall && bit_cnt_reg == 4'd8) begin
              bit_cnt_reg <= 4'd0;
              if (state_reg == S_ADDR) begin
                if (rx_byte_reg[7:1] == SLAVE_ADDR) begin
                  sda_low_reg <= 1'b1;
                  rw_read_reg <= rx_byte_reg[0];
                  state_reg   <= S_ADDR_ACK;
                  if (rx_byte_reg[0]) begin
                    shadow_reg   <= {rd_ms, rd_ls};
                    byte_idx_reg <= 1'b0;
                  end
                end else begin
                  state_reg <= S_WAIT;
                end
              end else begin
                sda_low_reg   <= 1'b1;
                cmd_byte_reg  <= rx_byte_reg;
                cmd_valid_reg <= 1'b1;
                state_reg     <= S_CMD_ACK;
              end
            end
          end

          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_read_reg) begin
                sda_low_reg <= ~shadow_reg[15];
                bit_cnt_reg <= 4'd1;
                state_reg   <= S_TX;
              end else begin
                sda_low_reg <= 1'b0;
                state_reg   <= S_CMD;
              end
            end
          end

          S_CMD_ACK: begin
            if (scl_fall) begin
              sda_low_reg <= 1'b0;
              state_reg   <= S_WAIT;
            end
          end

          S_TX: begin
            if (scl_fall) begin
              if (bit_cnt_reg == 4'd8) begin
                sda_low_reg  <= 1'b0;
                ack_seen_reg <= 1'b0;
                state_reg    <= S_TX_ACK;
              end else begin
                sda_low_reg <= ~shadow_reg[tx_bit_idx];
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end

          S_TX_ACK: begin
            if (scl_rise) begin
              if (byte_idx_reg) begin
                rd_done_reg <= 1'b1;
                state_reg   <= S_WAIT;
              end else if (sda_sync_reg) begin
                state_reg <= S_WAIT;
              end else begin
                ack_seen_reg <= 1'b1;
              end
            end else if (scl_fall && ack_seen_reg) begin
              // MSB acknowledged: start the LSB on this falling edge
              byte_idx_reg <= 1'b1;
              sda_low_reg  <= ~shadow_reg[7];
              bit_cnt_reg  <= 4'd1;
              state_reg    <= S_TX;
            end
          end

          S_IDLE, S_WAIT: begin
            // Only START/STOP leave these states
          end

          default: begin
            state_reg   <= S_IDLE;
            sda_low_reg <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_slave_responder.sv
// ----------------------------------------------------------------------------
// tb_iic_slave_responder
//
// Bus-master bench for iic_slave_responder. A directed table of transactions
// is applied first, then a reset-during-read sequence, then randomized
// transactions whose expected results come from a transaction-level model.
// ----------------------------------------------------------------------------
module tb_iic_slave_responder;

  localparam logic [6:0] ADDR = 7'h40;
  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] rd_ms = 8'h00;
  logic [7:0] rd_ls = 8'h00;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic       rd_done;
  logic       busy;
  wire        sda_bus;

  pullup pu_sda (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  iic_slave_responder #(.SLAVE_ADDR(ADDR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda_bus),
    .rd_ms    (rd_ms),
    .rd_ls    (rd_ls),
    .cmd_byte (cmd_byte),
    .cmd_valid(cmd_valid),
    .rd_done  (rd_done),
    .busy     (busy)
  );

  // Pulse monitors: high-cycle counts and overlap count
  int cv_cycles = 0;
  int rd_cycles = 0;
  int overlap   = 0;
  always @(negedge clk) begin
    if (cmd_valid) cv_cycles <= cv_cycles + 1;
    if (rd_done) rd_cycles <= rd_cycles + 1;
    if (cmd_valid && rd_done) overlap <= overlap + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] a1;
    logic [7:0] c;
    logic       rs;
    logic [7:0] a2;
    logic [7:0] ms;
    logic [7:0] ls;
    logic       ack0;
    logic       e_ack1;
    logic       e_ackc;
    logic       e_ack2;
    logic [7:0] e_b0;
    logic [7:0] e_b1;
    int         e_cmd_cnt;
    int         e_rd_cnt;
    logic [7:0] e_cmd;
  } vec_t;

  // Transaction-level reference: which bytes get acknowledged and what data
  // the master sees, given only the address/command/read rules.
  function automatic vec_t model(input vec_t v, input logic [7:0] prev_cmd);
    vec_t r;
    logic wr_ok;
    logic rd_ok;
    logic [7:0] raddr;
    r = v;
    r.e_ack1    = (v.a1[7:1] == ADDR);
    wr_ok       = (v.a1 == {ADDR, 1'b0});
    r.e_ackc    = wr_ok;
    r.e_cmd_cnt = wr_ok ? 1 : 0;
    r.e_cmd     = wr_ok ? v.c : prev_cmd;
    r.e_ack2    = (v.a2[7:1] == ADDR);
    raddr       = v.a1[0] ? v.a1 : v.a2;
    rd_ok       = (v.a1[0] || v.rs) && (raddr == {ADDR, 1'b1});
    r.e_b0      = rd_ok ? v.ms : 8'hFF;
    r.e_b1      = (rd_ok && v.ack0) ? v.ls : 8'hFF;
    r.e_rd_cnt  = (rd_ok && v.ack0) ? 1 : 0;
    return r;
  endfunction

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  // START from idle (scl high) or repeated START (scl low)
  task automatic bus_start();
    if (scl == 1'b0) begin
      wq(Q); m_low = 1'b0; wq(Q); scl = 1'b1; wq(2 * Q);
    end
    m_low = 1'b1; wq(2 * Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wq(Q); m_low = 1'b1; wq(Q); scl = 1'b1; wq(2 * Q); m_low = 1'b0; wq(2 * Q);
  endtask

  // One SCL clock: master puts b on the bus (1 = release), returns bus value
  task automatic bus_bit(input logic b, output logic r);
    wq(Q); m_low = ~b; wq(Q); scl = 1'b1; wq(Q); r = sda_bus; wq(Q); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask

  // Read one byte; when perturb is set the host registers change mid-byte
  task automatic recv_byte(input logic ack, input logic perturb, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
      if (perturb && i == 6) begin
        rd_ms = 8'($urandom);
        rd_ls = 8'($urandom);
      end
    end
    bus_bit(~ack, r);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic ack1, ackc, ack2, do_rd;
    logic [7:0] b0, b1;
    int cv0, rd0, ov0;
    ackc = 1'b0; ack2 = 1'b0; b0 = 8'hFF; b1 = 8'hFF;
    cv0 = cv_cycles; rd0 = rd_cycles; ov0 = overlap;
    rd_ms = v.ms; rd_ls = v.ls;
    bus_start();
    chk("busy_after_start", busy, 1);
    send_byte(v.a1, ack1);
    chk("ack_addr1", ack1, v.e_ack1);
    do_rd = v.a1[0];
    if (!v.a1[0]) begin
      send_byte(v.c, ackc);
      chk("ack_cmd", ackc, v.e_ackc);
      if (v.rs) begin
        bus_start();
        send_byte(v.a2, ack2);
        chk("ack_addr2", ack2, v.e_ack2);
        do_rd = 1'b1;
      end
    end
    if (do_rd) begin
      recv_byte(v.ack0, 1'b1, b0);
      recv_byte(1'b0, 1'b0, b1);
      chk("read_msb", b0, v.e_b0);
      chk("read_lsb", b1, v.e_b1);
    end
    bus_stop();
    chk("busy_after_stop", busy, 0);
    chk("sda_released", sda_bus, 1);
    chk("cmd_byte", cmd_byte, v.e_cmd);
    chk("cmd_valid_cycles", cv_cycles - cv0, v.e_cmd_cnt);
    chk("rd_done_cycles", rd_cycles - rd0, v.e_rd_cnt);
    chk("pulse_overlap", overlap - ov0, 0);
    $display("txn %0d a1=%02h c=%02h rs=%0d a2=%02h ack0=%0d acks=%0d%0d%0d rd=%02h_%02h cmd=%02h",
             idx, v.a1, v.c, v.rs, v.a2, v.ack0, ack1, ackc, ack2, b0, b1, cmd_byte);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t       tbl[7];
  vec_t       v;
  logic [7:0] exp_cmd;
  logic [6:0] a7;
  logic       ack;

  initial begin
    // Reset values
    #2 rst_n = 1'b0;
    wq(4);
    chk("rst_sda", sda_bus, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_rd_done", rd_done, 0);
    rst_n = 1'b1;
    wq(4);

    // Directed transactions with hand-derived expectations
    tbl[0] = '{a1:8'h80, c:8'hE3, rs:1'b0, a2:8'h00, ms:8'h66, ls:8'h5C, ack0:1'b1,
               e_ack1:1'b1, e_ackc:1'b1, e_ack2:1'b0, e_b0:8'hFF, e_b1:8'hFF,
               e_cmd_cnt:1, e_rd_cnt:0, e_cmd:8'hE3};
    tbl[1] = '{a1:8'h80, c:8'hE5, rs:1'b1, a2:8'h81, ms:8'h66, ls:8'h5C, ack0:1'b1,
               e_ack1:1'b1, e_ackc:1'b1, e_ack2:1'b1, e_b0:8'h66, e_b1:8'h5C,
               e_cmd_cnt:1, e_rd_cnt:1, e_cmd:8'hE5};
    tbl[2] = '{a1:8'h82, c:8'hE3, rs:1'b0, a2:8'h00, ms:8'h66, ls:8'h5C, ack0:1'b1,
               e_ack1:1'b0, e_ackc:1'b0, e_ack2:1'b0, e_b0:8'hFF, e_b1:8'hFF,
               e_cmd_cnt:0, e_rd_cnt:0, e_cmd:8'hE5};
    tbl[3] = '{a1:8'h81, c:8'h00, rs:1'b0, a2:8'h00, ms:8'h66, ls:8'h5C, ack0:1'b0,
               e_ack1:1'b1, e_ackc:1'b0, e_ack2:1'b0, e_b0:8'h66, e_b1:8'hFF,
               e_cmd_cnt:0, e_rd_cnt:0, e_cmd:8'hE5};
    tbl[4] = '{a1:8'h80, c:8'hE3, rs:1'b1, a2:8'h81, ms:8'h66, ls:8'h5C, ack0:1'b1,
               e_ack1:1'b1, e_ackc:1'b1, e_ack2:1'b1, e_b0:8'h66, e_b1:8'h5C,
               e_cmd_cnt:1, e_rd_cnt:1, e_cmd:8'hE3};
    tbl[5] = '{a1:8'h83, c:8'h00, rs:1'b0, a2:8'h00, ms:8'hA5, ls:8'h3C, ack0:1'b1,
               e_ack1:1'b0, e_ackc:1'b0, e_ack2:1'b0, e_b0:8'hFF, e_b1:8'hFF,
               e_cmd_cnt:0, e_rd_cnt:0, e_cmd:8'hE3};
    tbl[6] = '{a1:8'h80, c:8'hF3, rs:1'b1, a2:8'h83, ms:8'h12, ls:8'h34, ack0:1'b1,
               e_ack1:1'b1, e_ackc:1'b1, e_ack2:1'b0, e_b0:8'hFF, e_b1:8'hFF,
               e_cmd_cnt:1, e_rd_cnt:0, e_cmd:8'hF3};
    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Reset while the slave drives a 0 data bit
    rd_ms = 8'h00; rd_ls = 8'h00;
    bus_start();
    send_byte(8'h81, ack);
    chk("rst_seq_addr_ack", ack, 1);
    wq(Q); scl = 1'b1; wq(Q);
    chk("rst_seq_slave_drives", sda_bus, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_seq_sda", sda_bus, 1);
    chk("rst_seq_busy", busy, 0);
    chk("rst_seq_cmd_byte", cmd_byte, 8'h00);
    chk("rst_seq_cmd_valid", cmd_valid, 0);
    chk("rst_seq_rd_done", rd_done, 0);
    wq(3);
    rst_n = 1'b1;
    wq(4);
    exp_cmd = 8'h00;
    v = '{a1:8'h80, c:8'h5A, rs:1'b0, a2:8'h00, ms:8'h00, ls:8'h00, ack0:1'b1,
          e_ack1:1'b0, e_ackc:1'b0, e_ack2:1'b0, e_b0:8'h00, e_b1:8'h00,
          e_cmd_cnt:0, e_rd_cnt:0, e_cmd:8'h00};
    v = model(v, exp_cmd);
    run_vec(7, v);
    exp_cmd = v.e_cmd;

    // Randomized transactions against the reference model
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0: v.a1 = 8'h80;
        1: v.a1 = 8'h81;
        2: begin
          a7 = 7'($urandom);
          if (a7 == ADDR) a7 = 7'h3F;
          v.a1 = {a7, 1'($urandom)};
        end
        default: v.a1 = 8'h80;
      endcase
      v.c    = 8'($urandom);
      v.rs   = 1'($urandom);
      v.a2   = ($urandom_range(0, 2) != 0) ? 8'h81 : {7'($urandom), 1'b1};
      v.ms   = 8'($urandom);
      v.ls   = 8'($urandom);
      v.ack0 = 1'($urandom);
      v = model(v, exp_cmd);
      run_vec(8 + n, v);
      exp_cmd = v.e_cmd;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
